// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared constants, fetch FSM states and opcode predecode.
package instruction_fetch_unit_pkg;
  localparam logic RESET = 1'b0;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int PROGRAM_ADDRESS_WIDTH = 6;
  typedef enum logic [1:0] {S_BOOT, S_RUN, S_PAUSED} fetch_state_type;
  typedef enum logic [6:0] {
    LOAD = 7'h03, LOAD_FP = 7'h07, OP_IMM = 7'h13, U_AUIPC = 7'h17,
    STORE = 7'h23, STORE_FP = 7'h27, OP = 7'h33, U_LUI = 7'h37,
    MADD = 7'h43, MSUB = 7'h47, NMSUB = 7'h4B, NMADD = 7'h4F,
    OP_FP = 7'h53, BRANCH = 7'h63, JALR = 7'h67, J_JAL = 7'h6F, SYSTEM = 7'h73
  } instruction_format_type;
  typedef enum logic [2:0] {R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE, SYS_TYPE} instruction_op_type;
  function automatic instruction_op_type predecode(input instruction_format_type f);
    case (f)
      OP, OP_FP, MADD, MSUB, NMSUB, NMADD: return R_TYPE;
      OP_IMM, JALR, LOAD, LOAD_FP:         return I_TYPE;
      STORE, STORE_FP:                     return S_TYPE;
      BRANCH:                              return B_TYPE;
      U_AUIPC, U_LUI:                      return U_TYPE;
      J_JAL:                               return J_TYPE;
      default:                             return SYS_TYPE;
    endcase
  endfunction
endpackage

// File: rtl/ifu_fetch_fifo.sv
// ifu_fetch_fifo: small circular buffer with flush and same-cycle push/pop at any fill level.
module ifu_fetch_fifo
  import instruction_fetch_unit_pkg::*;
#(
  parameter int W = 8,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          valid,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd, wr_n, rd_n;
  always_comb begin
    wr_n = (wr == AW'(DEPTH - 1)) ? '0 : wr + 1'b1;
    rd_n = (rd == AW'(DEPTH - 1)) ? '0 : rd + 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET) begin
      mem <= '{default: '0};
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (push) mem[wr] <= wdata;
      if (push) wr <= wr_n;
      if (pop) rd <= rd_n;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign rdata = mem[rd];
  assign valid = count != '0;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC generation, program-memory requests and buffered handoff to decode.
// Define IFU_PREDECODE_EN to add the per-entry predecoded id_op_type output.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int INSTR_W = INSTRUCTION_WIDTH,
  parameter int ADDR_W = PROGRAM_ADDRESS_WIDTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc
`ifdef IFU_PREDECODE_EN
  , output instruction_op_type id_op_type
`endif
);
`ifdef IFU_PREDECODE_EN
  localparam int EW = INSTR_W + ADDR_W + 3;
`else
  localparam int EW = INSTR_W + ADDR_W;
`endif
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  fetch_state_type state, state_d;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_d, inflight_pc;
  logic inflight, deq, push, room;
  logic [CW-1:0] count;
  logic [EW-1:0] wdata, rdata;
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET) begin
      state <= S_BOOT;
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state <= state_d;
      fetch_pc <= fetch_pc_d;
      inflight <= imem_req;
      if (imem_req) inflight_pc <= imem_addr;
    end
  end
  // A redirect flushes the buffer and kills the arriving response, so it always has room.
  always_comb begin
    state_d = fetch_en ? S_RUN : S_PAUSED;
    deq = id_valid & id_ready & ~redirect_valid;
    room = int'(count) + int'(inflight) - int'(deq) < FIFO_DEPTH;
    imem_req = (state == S_RUN) && fetch_en && (redirect_valid || room);
    imem_addr = redirect_valid ? redirect_pc : fetch_pc;
    fetch_pc_d = imem_req ? imem_addr + 1'b1 : imem_addr;
    push = inflight & ~redirect_valid;
  end
`ifdef IFU_PREDECODE_EN
  assign wdata = {predecode(instruction_format_type'(imem_rdata[6:0])), imem_rdata, inflight_pc};
  assign id_op_type = instruction_op_type'(rdata[EW-1 -: 3]);
`else
  assign wdata = {imem_rdata, inflight_pc};
`endif
  assign id_instr = rdata[ADDR_W +: INSTR_W];
  assign id_pc = rdata[ADDR_W-1:0];
  ifu_fetch_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(redirect_valid),
    .push(push),
    .pop(deq),
    .wdata(wdata),
    .rdata(rdata),
    .valid(id_valid),
    .count(count)
  );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed and random fetch traffic checked against a queue-based model.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;
  logic clk = 0, rst = 0, fetch_en = 0, redirect_valid = 0, id_ready = 0;
  logic [5:0] redirect_pc = '0;
  logic imem_req, id_valid, req62, valid62;
  logic [5:0] imem_addr, id_pc, addr62, pc62;
  logic [31:0] imem_rdata = '0, rdata62 = '0, id_instr, instr62;
`ifdef IFU_PREDECODE_EN
  instruction_op_type id_op_type, op62;
`endif
  logic [31:0] mem_img [64];
  int checks = 0, errors = 0, cyc = 0, first_v = -1;
  int mq[$], seen62[$];
  bit m_run = 0, m_infl = 0, collect62 = 0;
  int m_infl_pc = 0, m_fpc = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit u_dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc)
`ifdef IFU_PREDECODE_EN
    , .id_op_type(id_op_type)
`endif
  );

  instruction_fetch_unit #(.RESET_PC(6'd62)) u_dut62 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(req62), .imem_addr(addr62),
    .imem_rdata(rdata62), .id_valid(valid62), .id_ready(id_ready),
    .id_instr(instr62), .id_pc(pc62)
`ifdef IFU_PREDECODE_EN
    , .id_op_type(op62)
`endif
  );

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_img[imem_addr];
    if (req62) rdata62 <= mem_img[addr62];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef IFU_PREDECODE_EN
  function automatic int ref_op(input logic [6:0] o);
    case (o)
      7'h33, 7'h53, 7'h43, 7'h47, 7'h4B, 7'h4F: return 0;
      7'h13, 7'h67, 7'h03, 7'h07: return 1;
      7'h23, 7'h27: return 2;
      7'h63: return 3;
      7'h37, 7'h17: return 4;
      7'h6F: return 5;
      default: return 6;
    endcase
  endfunction
`endif

  task automatic model_reset();
    mq.delete();
    m_run = 0;
    m_infl = 0;
    m_fpc = 0;
    cyc = 0;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance model at the edge.
  task automatic step(input bit fe, input bit rv, input int rpc, input bit rdy);
    bit exp_valid, exp_req;
    int deq, exp_addr;
    fetch_en = fe;
    redirect_valid = rv;
    redirect_pc = 6'(rpc);
    id_ready = rdy;
    #1;
    exp_valid = mq.size() != 0;
    deq = (exp_valid && rdy && !rv) ? 1 : 0;
    exp_req = m_run && fe && (rv || (mq.size() + int'(m_infl) - deq) < 2);
    exp_addr = rv ? rpc : m_fpc;
    if (id_valid && first_v < 0) first_v = cyc;
    chk("id_valid", 64'(id_valid), 64'(exp_valid));
    if (exp_valid) begin
      chk("id_pc", 64'(id_pc), 64'(mq[0]));
      chk("id_instr", 64'(id_instr), 64'(mem_img[mq[0]]));
`ifdef IFU_PREDECODE_EN
      chk("id_op_type", 64'(id_op_type), 64'(ref_op(mem_img[mq[0]][6:0])));
`endif
    end
    chk("imem_req", 64'(imem_req), 64'(exp_req));
    if (exp_req) chk("imem_addr", 64'(imem_addr), 64'(exp_addr));
    if (collect62 && valid62) begin
      seen62.push_back(int'(pc62));
      chk("instr62", 64'(instr62), 64'(mem_img[pc62]));
    end
    @(posedge clk);
    if (rv) mq.delete();
    else begin
      if (deq != 0) void'(mq.pop_front());
      if (m_infl) mq.push_back(m_infl_pc);
    end
    m_infl = exp_req;
    m_infl_pc = exp_addr;
    m_fpc = exp_req ? (exp_addr + 1) % 64 : exp_addr;
    m_run = fe;
    cyc++;
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 64'(imem_req), 64'(0));
    chk({tag, "_addr"}, 64'(imem_addr), 64'(0));
    chk({tag, "_valid"}, 64'(id_valid), 64'(0));
    chk({tag, "_instr"}, 64'(id_instr), 64'(0));
    chk({tag, "_pc"}, 64'(id_pc), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_img[i] = ($urandom() & 32'hFFFF_FFC0) | 32'(i);
    mem_img[50] = 32'h0000_0063;
    mem_img[51] = 32'h0000_006F;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
`ifdef IFU_PREDECODE_EN
    chk("reset_op", 64'(id_op_type), 64'(0));
`endif
    rst = 1;
    model_reset();
    collect62 = 1;
    for (int i = 0; i < 12; i++) step(1, 0, 0, 1);
    collect62 = 0;
    chk("latency", 64'(first_v), 64'(3));
    chk("wrap62_n", 64'(seen62.size() >= 4), 64'(1));
    if (seen62.size() >= 4) begin
      chk("wrap62_0", 64'(seen62[0]), 64'(62));
      chk("wrap62_1", 64'(seen62[1]), 64'(63));
      chk("wrap62_2", 64'(seen62[2]), 64'(0));
      chk("wrap62_3", 64'(seen62[3]), 64'(1));
    end
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 40, 0);
    step(1, 0, 0, 1);
    chk("redir_valid", 64'(id_valid), 64'(1));
    chk("redir_target", 64'(id_pc), 64'(40));
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
    step(1, 1, 62, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 1);
    step(1, 1, 50, 1);
    step(1, 0, 0, 1);
`ifdef IFU_PREDECODE_EN
    chk("op_branch", 64'(id_op_type), 64'(B_TYPE));
`endif
    step(1, 0, 0, 1);
`ifdef IFU_PREDECODE_EN
    chk("op_jal", 64'(id_op_type), 64'(J_TYPE));
`endif
    step(1, 1, 7, 1);
    step(0, 1, 20, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
           int'($urandom_range(0, 63)), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
    redirect_valid = 0;
    #2;
    rst = 0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1;
    model_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0, $urandom_range(0, 1) != 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of decode.
- Generates the word-addressed PC and drives synchronous program memory (1-cycle read latency).
- Buffers returned instructions in a small FIFO and hands {instr, pc} to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush the buffer and squash the in-flight read.

Parameters:
- INSTR_W, 32 (= INSTRUCTION_WIDTH): instruction width.
- ADDR_W, 6 (= PROGRAM_ADDRESS_WIDTH): program word-address width.
- RESET_PC, 0: first fetch address after reset.
- FIFO_DEPTH, 2: fetch buffer entries, minimum 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when rst == RESET).
- fetch_en  in  1  permits new memory requests.
- redirect_valid  in  1  redirect command from execute.
- redirect_pc  in  ADDR_W  redirect target word address.
- imem_req  out  1  read enable to program memory.
- imem_addr  out  ADDR_W  read word address.
- imem_rdata  in  INSTR_W  read data, valid the cycle after imem_req.
- id_valid  out  1  head entry valid toward decode.
- id_ready  in  1  decode accepts the head entry.
- id_instr  out  INSTR_W  head instruction.
- id_pc  out  ADDR_W  head instruction's word address.

Behaviour:
- Reset (async, active-low): all state cleared.
  - FSM = S_BOOT; fetch_pc = RESET_PC; FIFO empty; inflight = 0.
  - Outputs: imem_req = 0, imem_addr = RESET_PC, id_valid = 0, id_instr = 0, id_pc = 0.
  - Reset during an outstanding read discards that read.
- FSM states:
  - S_BOOT: one cycle, no request issued. Next state is S_RUN if fetch_en, else S_PAUSED.
  - S_RUN: goes to S_PAUSED when fetch_en = 0.
  - S_PAUSED: no new requests; the in-flight read still completes. Goes to S_RUN when fetch_en = 1.
- Issue rule: imem_req = 1 when state == S_RUN and (count + inflight − deq) < FIFO_DEPTH.
  - deq = id_valid & id_ready & !redirect_valid.
  - On issue: imem_addr = fetch_pc; fetch_pc increments mod 2^ADDR_W (63 → 0 at ADDR_W = 6); inflight is set and inflight_pc is captured.
- Response: in the cycle after an issue, imem_rdata is enqueued with inflight_pc at the clock edge, unless squashed.
- Throughput: with id_ready held high, one instruction per cycle in steady state.
- Latency: reset deassert → S_BOOT → request at cycle 1 → id_valid = 1 at cycle 3 (measured in rising edges after deassert).
- FIFO: id_valid = (count != 0); id_instr and id_pc come from the head entry.
  - Enqueue and dequeue in the same cycle is legal at any count.
  - The issue rule guarantees no overflow.
  - Dequeue while empty is impossible, since id_valid = 0.
- Redirect (highest priority), when redirect_valid = 1 in cycle t:
  - FIFO flushed (count = 0); any id handshake in cycle t is ignored.
  - Response arriving in t is dropped.
  - If the state is S_RUN: imem_req = 1 and imem_addr = redirect_pc in t (bypass); fetch_pc = redirect_pc + 1. The target reaches id_valid in t + 2.
  - If the state is S_PAUSED or S_BOOT: no request; fetch_pc = redirect_pc.
- Back-to-back redirects: the last one wins; every earlier response is squashed.
- Redirect together with fetch_en falling: the flush and PC update apply, and no request is issued.

Optional Feature:
- Macro: IFU_PREDECODE_EN.
- When defined:
  - Adds output id_op_type (3 bits, instruction_op_type).
  - Computed from imem_rdata[6:0] at enqueue and stored per FIFO entry.
  - OP / OP_FP / MADD / MSUB / NMSUB / NMADD → R_TYPE.
  - OP_IMM / JALR / LOAD / LOAD_FP → I_TYPE.
  - STORE / STORE_FP → S_TYPE.
  - BRANCH → B_TYPE.
  - U_AUIPC / U_LUI → U_TYPE.
  - J_JAL → J_TYPE.
  - SYSTEM and any unlisted opcode → SYS_TYPE.
  - id_op_type resets to R_TYPE.
- When undefined: the port and its storage are absent; behaviour is otherwise identical.

Decomposition:
- Package common gains:
  - fetch_state_type enum {S_BOOT, S_RUN, S_PAUSED};
  - a predecode function mapping instruction_format_type to instruction_op_type.
- Reused from common: RESET, INSTRUCTION_WIDTH, PROGRAM_ADDRESS_WIDTH.
- Sub-module ifu_fetch_fifo: parameterised FIFO holding {instr, pc[, op_type]}, with count output, flush, and same-cycle push/pop.

Test Plan:
- Reset, then fetch_en = 1, id_ready = 1, with memory returning word = address → id_valid first at cycle 3; id_pc 0, 1, 2, … on consecutive cycles; id_instr matches id_pc.
- id_ready = 0 for 5 cycles mid-stream → count saturates at 2 with no lost or duplicated pc; after release, the sequence resumes contiguous.
- redirect_valid pulse with redirect_pc = 40 while FIFO is full and a read is in flight → stale entries never appear; id_pc = 40 at t + 2, then 41, 42.
- Run from RESET_PC = 62 → id_pc sequence 62, 63, 0, 1 (wrap-around).
- fetch_en = 0 for 4 cycles, then 1 → no imem_req while paused; in-flight instruction still delivered; fetch resumes at the next sequential pc.
- With IFU_PREDECODE_EN: memory returns 0x00000063 (BRANCH) then 0x0000006F (J_JAL) → id_op_type = B_TYPE, then J_TYPE.
- Assert rst low mid-stream → all outputs reset immediately; the sequence restarts at RESET_PC after deassert.
